// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the 3x3 window generator and downstream MAC: clears and enables the
// generator for one frame, waits for matching MAC results, with abort and a progress watchdog.
module conv_frame_ctrl #(
  parameter int unsigned WIDTH   = 480,
  parameter int unsigned HEIGHT  = 272,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CNT_W   = $clog2(WIDTH * HEIGHT + 1)
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic             iAbort,
  output logic             oWinRstN,
  output logic             oWinEn,
  output logic             oWinBusy,
  input  logic             iWinValid,
  input  logic             iMacBusy,
  input  logic             iMacValid,
  output logic             oBusy,
  output logic             oDone,
  output logic             oAborted,
  output logic             oErr,
  output logic [CNT_W-1:0] oWinCnt,
  output logic [CNT_W-1:0] oResCnt,
  output logic [15:0]      oFrameCnt
);

  localparam int unsigned TOTAL = WIDTH * HEIGHT;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TotalC = CNT_W'(TOTAL);
  localparam logic [WD_W-1:0]  WdLast = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StClr, StRun, StDrain, StDone, StAbort, StErr} stateT;

  stateT            stateQ, stateD;
  logic [CNT_W-1:0] winCntQ, winCntD, resCntQ, resCntD;
  logic [WD_W-1:0]  wdQ, wdD;
  logic [15:0]      frameCntQ;
  logic             winRstNQ, doneQ, abortedQ, errQ, busyQ;
  logic             winHit, macHit;

  always_comb begin
    stateD  = stateQ;
    winCntD = winCntQ;
    resCntD = resCntQ;
    wdD     = wdQ;
    winHit  = 1'b0;
    macHit  = 1'b0;
    case (stateQ)
      StIdle: if (iStart) stateD = StClr;
      StClr: begin
        winCntD = '0;
        resCntD = '0;
        wdD     = '0;
        stateD  = StRun;
      end
      StRun, StDrain: begin
        winHit = (stateQ == StRun) && iWinValid;
        // Results beyond a full frame saturate silently.
        macHit = iMacValid && (resCntQ != TotalC);
        if (winHit) winCntD = winCntQ + CNT_W'(1);
        if (macHit) resCntD = resCntQ + CNT_W'(1);
        wdD = (winHit || macHit) ? '0 : wdQ + WD_W'(1);
        if (winHit && (winCntQ == TotalC - CNT_W'(1))) begin
          stateD = (resCntD == TotalC) ? StDone : StDrain;
        end else if ((stateQ == StDrain) && (resCntD == TotalC)) begin
          stateD = StDone;
        end else if (!(winHit || macHit) && (wdQ == WdLast)) begin
          stateD = StErr;
        end
      end
      StDone, StAbort: stateD = StIdle;
      StErr: stateD = StErr;
      default: stateD = StIdle;
    endcase
    if (iAbort && (stateQ != StIdle)) stateD = StAbort;
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      stateQ    <= StIdle;
      winCntQ   <= '0;
      resCntQ   <= '0;
      wdQ       <= '0;
      frameCntQ <= '0;
      winRstNQ  <= 1'b1;
      doneQ     <= 1'b0;
      abortedQ  <= 1'b0;
      errQ      <= 1'b0;
      busyQ     <= 1'b0;
    end else begin
      stateQ   <= stateD;
      winCntQ  <= winCntD;
      resCntQ  <= resCntD;
      wdQ      <= wdD;
      if ((stateD == StDone) && (stateQ != StDone)) frameCntQ <= frameCntQ + 16'd1;
      // Generator clear is a flop so its asynchronous reset input never sees decode glitches.
      winRstNQ <= !((stateD == StClr) || (stateD == StAbort) || (stateD == StErr));
      doneQ    <= (stateD == StDone);
      abortedQ <= (stateD == StAbort);
      errQ     <= (stateD == StErr);
      busyQ    <= (stateD != StIdle);
    end
  end

  assign oWinEn    = (stateQ == StRun);
  assign oWinBusy  = iMacBusy;
  assign oWinRstN  = winRstNQ;
  assign oDone     = doneQ;
  assign oAborted  = abortedQ;
  assign oErr      = errQ;
  assign oBusy     = busyQ;
  assign oWinCnt   = winCntQ;
  assign oResCnt   = resCntQ;
  assign oFrameCnt = frameCntQ;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Scoreboard bench for conv_frame_ctrl: a counting model predicts frame outcome events,
// a negedge monitor pops and compares them as the DUT reports them.
module tb_conv_frame_ctrl;
  localparam int W = 4, H = 3, TO = 16, TOTAL = W * H, LEN = 512;
  localparam int CW = $clog2(W * H + 1);
  localparam int KClr = 0, KDone = 1, KAbort = 2, KErr = 3;

  typedef struct {
    int kind;
    int cyc;
    int win;
    int res;
    int frm;
    int en;
  } evT;

  evT expQ[$];

  logic iClk = 1'b0, iRst = 1'b0, iStart = 1'b0, iAbort = 1'b0;
  logic iWinValid = 1'b0, iMacBusy = 1'b0, iMacValid = 1'b0;
  logic oWinRstN, oWinEn, oWinBusy, oBusy, oDone, oAborted, oErr;
  logic [CW-1:0] oWinCnt, oResCnt;
  logic [15:0] oFrameCnt;

  int cyc = 0, nChecks = 0, nFail = 0, tbFrames = 0;
  bit wv[LEN], mv[LEN], bz[LEN];
  bit monOn = 1'b0;

  conv_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .TIMEOUT(TO)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iAbort(iAbort),
    .oWinRstN(oWinRstN), .oWinEn(oWinEn), .oWinBusy(oWinBusy),
    .iWinValid(iWinValid), .iMacBusy(iMacBusy), .iMacValid(iMacValid),
    .oBusy(oBusy), .oDone(oDone), .oAborted(oAborted), .oErr(oErr),
    .oWinCnt(oWinCnt), .oResCnt(oResCnt), .oFrameCnt(oFrameCnt)
  );

  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge iClk);
    #1;
  endtask

  task automatic zeroIn();
    iStart = 0; iAbort = 0; iWinValid = 0; iMacValid = 0; iMacBusy = 0;
  endtask

  task automatic clearArrays();
    for (int c = 0; c < LEN; c++) begin
      wv[c] = 0; mv[c] = 0; bz[c] = 0;
    end
  endtask

  task automatic echo(input int lat);
    for (int c = 0; c + lat < LEN; c++) if (wv[c]) mv[c + lat] = 1;
  endtask

  // Windows issued whenever not stalled, until a frame's worth has been produced.
  task automatic fillWins(input int n);
    int k = 0;
    for (int c = 0; c < LEN && k < n; c++) if (!bz[c]) begin wv[c] = 1; k++; end
  endtask

  // Reference: count accepted windows/results per RUN cycle, track the last progress cycle.
  task automatic playFrame(input int abortAt);
    int wins, res, p, cLastW, kind, cEv, en, s;
    bit prog;
    wins = 0; res = 0; p = -1; cLastW = -1; kind = -1; cEv = LEN - 1;
    for (int c = 0; c < LEN; c++) begin
      prog = 0;
      if (c == abortAt) begin kind = KAbort; cEv = c; break; end
      if (cLastW < 0 && wv[c]) begin
        wins++; prog = 1;
        if (wins == TOTAL) cLastW = c;
      end
      if (mv[c] && res < TOTAL) begin res++; prog = 1; end
      if (prog) p = c;
      else if (c - p == TO) begin kind = KErr; cEv = c; break; end
      if (cLastW >= 0 && res == TOTAL) begin kind = KDone; cEv = c; break; end
    end
    en = ((cLastW >= 0 && cLastW < cEv) ? cLastW : cEv) + 1;
    step();
    s = cyc + 1;
    expQ.push_back('{KClr, s, 0, 0, tbFrames, 0});
    if (kind == KDone) begin
      tbFrames++;
      expQ.push_back('{KDone, s + 2 + cEv, TOTAL, TOTAL, tbFrames, en});
    end else if (kind == KErr) begin
      expQ.push_back('{KErr, s + 2 + cEv, wins, res, tbFrames, en});
      expQ.push_back('{KAbort, s + 7 + cEv, 0, 0, tbFrames, en});
    end else if (kind == KAbort) begin
      expQ.push_back('{KAbort, s + 2 + cEv, 0, 0, tbFrames, en});
    end
    iStart = 1;
    step();
    iStart = 0;
    for (int c = 0; c <= cEv; c++) begin
      step();
      iWinValid = wv[c]; iMacValid = mv[c]; iMacBusy = bz[c]; iAbort = (c == abortAt);
    end
    if (kind == KErr) begin
      for (int k = 1; k <= 5; k++) begin
        step();
        zeroIn();
        iStart = (k <= 3);
        iAbort = (k == 5);
      end
    end
    step(); zeroIn();
    step(); step();
  endtask

  initial begin : monitor
    bit pRst, pErr;
    int enCnt, k;
    evT e;
    pRst = 1; pErr = 0; enCnt = 0;
    forever begin
      @(negedge iClk);
      if (!iRst || !monOn) begin
        pRst = 1; pErr = 0; enCnt = 0;
        continue;
      end
      chk("win_busy_passthru", oWinBusy, iMacBusy);
      if (oWinEn) enCnt++;
      if (oDone || oAborted || (oErr && !pErr) || (!oWinRstN && pRst)) begin
        k = oAborted ? KAbort : oErr ? KErr : oDone ? KDone : KClr;
        if (expQ.size() == 0) chk("unexpected_event", k, -1);
        else begin
          e = expQ.pop_front();
          chk("event_kind", k, e.kind);
          chk("event_cycle", cyc, e.cyc);
          chk("frame_cnt", oFrameCnt, e.frm);
          chk("busy", oBusy, 1);
          if (e.kind == KClr) begin
            chk("clr_win_en", oWinEn, 0);
            enCnt = 0;
          end else chk("win_en_cycles", enCnt, e.en);
          if (e.kind == KDone || e.kind == KErr) begin
            chk("win_cnt", oWinCnt, e.win);
            chk("res_cnt", oResCnt, e.res);
          end
          if (e.kind == KDone) chk("done_rstn", oWinRstN, 1);
          if (e.kind == KErr) begin
            chk("err_rstn", oWinRstN, 0);
            chk("err_win_en", oWinEn, 0);
          end
          if (e.kind == KAbort) begin
            chk("abort_err_clear", oErr, 0);
            chk("abort_rstn", oWinRstN, 0);
          end
        end
      end
      pRst = oWinRstN;
      pErr = oErr;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  task automatic chkReset(input string tag);
    chk({tag, "_rstn"}, oWinRstN, 1);
    chk({tag, "_win_en"}, oWinEn, 0);
    chk({tag, "_busy"}, oBusy, 0);
    chk({tag, "_done"}, oDone, 0);
    chk({tag, "_aborted"}, oAborted, 0);
    chk({tag, "_err"}, oErr, 0);
    chk({tag, "_win_cnt"}, oWinCnt, 0);
    chk({tag, "_res_cnt"}, oResCnt, 0);
    chk({tag, "_frame_cnt"}, oFrameCnt, 0);
    chk({tag, "_win_busy"}, oWinBusy, iMacBusy);
  endtask

  initial begin
    int lat, gapAt, gapLen, abortAt;
    step(); step();
    iMacBusy = 1; #1;
    chkReset("reset");
    iMacBusy = 0;
    iRst = 1;
    monOn = 1;
    step();

    // Echo latency 3: DRAIN then done.
    clearArrays(); fillWins(TOTAL); echo(3); playFrame(-1);
    // Zero-latency MAC: straight to DONE.
    clearArrays(); fillWins(TOTAL); echo(0); playFrame(-1);
    // Mid-frame 5-cycle MAC stall.
    clearArrays(); for (int c = 4; c < 9; c++) bz[c] = 1;
    fillWins(TOTAL); echo(2); playFrame(-1);
    // Valids stop after 7 windows: watchdog, start ignored, abort exits.
    clearArrays(); fillWins(7); echo(0); playFrame(-1);
    // Abort coincident with last window, then a clean frame.
    clearArrays(); fillWins(TOTAL); echo(3); playFrame(TOTAL - 1);
    clearArrays(); fillWins(TOTAL); echo(3); playFrame(-1);

    repeat (14) begin
      clearArrays();
      lat = $urandom_range(0, 4);
      gapAt = $urandom_range(0, 20);
      gapLen = ($urandom_range(0, 2) == 0) ? $urandom_range(10, 24) : 0;
      for (int c = 0; c < LEN; c++) begin
        bz[c] = ($urandom_range(0, 5) == 0) || (c >= gapAt && c < gapAt + gapLen);
        if ($urandom_range(0, 3) == 0) bz[c] = 1;
      end
      fillWins(TOTAL); echo(lat);
      abortAt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 25)) : -1;
      playFrame(abortAt);
    end

    // Asynchronous reset in the middle of DRAIN.
    clearArrays(); fillWins(TOTAL); echo(4);
    step();
    expQ.push_back('{KClr, cyc + 1, 0, 0, tbFrames, 0});
    iStart = 1;
    step();
    iStart = 0;
    for (int c = 0; c <= 13; c++) begin
      step();
      iWinValid = wv[c]; iMacValid = mv[c];
    end
    #1;
    chk("drain_busy", oBusy, 1);
    chk("drain_win_en", oWinEn, 0);
    #1 iRst = 0;
    #1 chkReset("async_reset");
    step(); zeroIn();
    step(); iRst = 1;
    step(); step();
    chk("scoreboard_empty", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/conv_frame_ctrl.md
# conv_frame_ctrl

Frame-level sequencer for the 3x3 RGB888 window generator and the downstream MAC. On a start request it clears the window generator and enables it for exactly one frame of WIDTH×HEIGHT windows. It then waits for the matching number of MAC results and reports completion. It also supports abort, flags a stall error through a progress watchdog, and counts completed frames.

## Interface
- WIDTH, 480, image width in pixels
- HEIGHT, 272, image height in pixels
- TIMEOUT, 4096, number of consecutive no-progress cycles in RUN/DRAIN that trigger ERR (≥2)
- CNT_W, $clog2(WIDTH*HEIGHT+1), width of the window and result counters
- iClk  in  1  clock
- iRst  in  1  asynchronous, active-low reset
- iStart  in  1  start-frame request, sampled only in IDLE
- iAbort  in  1  abort request, highest priority in every non-IDLE state
- oWinRstN  out  1  active-low clear to the window generator's reset
- oWinEn  out  1  window generator enable
- oWinBusy  out  1  stall to the window generator
- iWinValid  in  1  window generator output-valid
- iMacBusy  in  1  MAC stall request
- iMacValid  in  1  MAC result strobe
- oBusy  out  1  frame in progress
- oDone  out  1  one-cycle frame-complete pulse
- oAborted  out  1  one-cycle abort pulse
- oErr  out  1  watchdog error, sticky
- oWinCnt  out  CNT_W  windows accepted this frame
- oResCnt  out  CNT_W  results accepted this frame
- oFrameCnt  out  16  completed frames, wraps at 0xFFFF→0

## Operation
- TOTAL = WIDTH*HEIGHT.
- States: IDLE, CLR, RUN, DRAIN, DONE, ABORT, ERR.
- IDLE:
  - iStart=1 → CLR.
  - oWinCnt and oResCnt hold their last values.
- CLR (exactly 1 cycle):
  - oWinRstN=0.
  - oWinCnt, oResCnt and the watchdog clear to 0.
  - → RUN.
- RUN:
  - oWinEn=1.
  - iWinValid increments oWinCnt.
  - iMacValid increments oResCnt.
  - On the edge where oWinCnt==TOTAL-1 and iWinValid=1:
    - → DONE if oResCnt will also equal TOTAL on that edge.
    - → DRAIN otherwise.
- DRAIN:
  - oWinEn=0.
  - iWinValid is ignored.
  - iMacValid increments oResCnt.
  - On the edge where oResCnt reaches TOTAL → DONE.
- DONE (1 cycle):
  - oDone=1.
  - oFrameCnt increments on DONE entry.
  - → IDLE.
- ABORT (1 cycle):
  - oWinRstN=0, oAborted=1.
  - → IDLE.
- ERR:
  - oErr=1, oWinRstN=0, oWinEn=0.
  - iStart is ignored.
  - Only iAbort exits, going to ABORT; oErr clears on ABORT entry.
- iAbort=1 in CLR/RUN/DRAIN/DONE/ERR → ABORT, overriding every other transition on that edge.
- iAbort in IDLE is ignored.
- Watchdog:
  - Counts in RUN and DRAIN.
  - Clears on any cycle with a counted iWinValid or iMacValid.
  - Otherwise increments.
  - On the edge where it would reach TOTAL... no: on the edge where it would reach TIMEOUT → ERR.
- iMacValid once oResCnt==TOTAL is ignored (saturates); it does not raise an error.
- oWinBusy = iMacBusy, combinational pass-through, in all states.
- oWinEn = (state==RUN), decoded from the state register.
- oBusy = 1 in CLR, RUN, DRAIN, DONE, ABORT and ERR.
- Counters are never sampled in IDLE, so any stale window-generator activity cannot corrupt a frame.

## Timing
- Reset values:
  - state IDLE.
  - oWinRstN=1, oWinEn=0, oBusy=0, oDone=0, oAborted=0, oErr=0.
  - All counters 0.
  - oWinBusy follows iMacBusy.
- iStart high in IDLE at edge N:
  - CLR during cycle N..N+1, with oWinRstN=0 in that cycle.
  - RUN from edge N+1; oWinEn=1 from edge N+1.
- oWinRstN is registered (glitch-free), because it drives an asynchronous reset.
- Last window at edge M:
  - oWinEn=0 from edge M.
  - The window generator is left mid-sequence; the next CLR resets it.
- oDone is high for exactly the cycle after the completing edge.
- The earliest next iStart is accepted in the cycle after DONE.
- Watchdog expiry: with no progress since edge K, ERR is entered at edge K+TIMEOUT.

## Test plan
- WIDTH=4, HEIGHT=3, TIMEOUT=16; iStart pulse; 12 iWinValid; MAC echoes 3 cycles later:
  - Required: oWinRstN low for 1 cycle.
  - oWinEn high until the 12th valid.
  - DRAIN entered, then oDone pulses 3 cycles later.
  - oFrameCnt=1; oWinCnt=oResCnt=12.
- Zero-latency MAC (iMacValid tied to iWinValid):
  - Required: RUN→DONE directly with no DRAIN cycle.
  - oDone is 1 cycle after the 12th valid.
- Hold iMacBusy high for 5 cycles mid-frame:
  - Required: oWinBusy mirrors it each cycle.
  - Counts are unchanged during the stall.
  - The frame still completes with 12 windows.
- Stop valids after 7 windows:
  - Required: ERR exactly 16 cycles after the last valid.
  - oErr=1, oWinRstN=0, iStart ignored.
  - iAbort → ABORT: oAborted pulse, oErr clears, IDLE.
- iAbort coincident with the 12th iWinValid:
  - Required: ABORT wins, no oDone, oFrameCnt unchanged.
  - The next iStart runs a full frame cleanly.
- Assert iRst mid-DRAIN:
  - Required: all outputs return to reset values immediately (asynchronously).
  - oFrameCnt=0.
